// File: rtl/alu_simd_arbiter.sv
// ============================================================================
// Module   : alu_simd_arbiter
// Brief    : Round-robin sharing of one pipelined N-lane SIMD adder among
//            M requesters, with a latency-matched tag pipeline for responses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_simd_arbiter #(
  parameter int M = 4,
  parameter int N = 4,
  parameter int W = 20,
  parameter int L = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [M-1:0]               req_valid_i,
  output logic [M-1:0]               req_ready_o,
  input  logic [M*N*W-1:0]           req_a_i,
  input  logic [M*N*W-1:0]           req_b_i,
  output logic [N*W-1:0]             alu_a_o,
  output logic [N*W-1:0]             alu_b_o,
  input  logic [N*W-1:0]             alu_res_i,
  output logic [M-1:0]               rsp_valid_o,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] rsp_id_o,
  output logic [N*W-1:0]             rsp_res_o,
  output logic                       busy_o
);

  localparam int IDW = (M > 1) ? $clog2(M) : 1;
  localparam int NW  = N * W;

  logic [IDW-1:0] ptr;
  logic           grant_v;
  logic [IDW-1:0] grant_id;
  logic [M-1:0]   grant;

  logic [L-1:0]   tag_v;
  logic [IDW-1:0] tag_id [L];
  logic [M-1:0]   rsp_onehot;

  // First valid requester scanning from ptr upward with wrap-around.
  always_comb begin
    int idx;
    grant_v  = 1'b0;
    grant_id = '0;
    grant    = '0;
    idx      = 0;
    for (int i = 0; i < M; i++) begin
      idx = int'(ptr) + i;
      if (idx >= M) idx = idx - M;
      if (!grant_v && req_valid_i[idx]) begin
        grant_v  = 1'b1;
        grant_id = idx[IDW-1:0];
      end
    end
    if (rst_i) grant_v = 1'b0;
    if (grant_v) grant[grant_id] = 1'b1;
  end

  assign req_ready_o = grant;
  assign alu_a_o     = grant_v ? req_a_i[int'(grant_id)*NW +: NW] : '0;
  assign alu_b_o     = grant_v ? req_b_i[int'(grant_id)*NW +: NW] : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr <= '0;
    end else if (grant_v) begin
      ptr <= (int'(grant_id) == M - 1) ? '0 : grant_id + 1'b1;
    end
  end

  // Tag stage i tracks the operation that the adder will present i+1 cycles
  // after issue; stage L-1 therefore lines up with alu_res_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_v <= '0;
      for (int i = 0; i < L; i++) tag_id[i] <= '0;
    end else begin
      tag_v[0]  <= grant_v;
      tag_id[0] <= grant_id;
      for (int i = 1; i < L; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  always_comb begin
    rsp_onehot = '0;
    for (int r = 0; r < M; r++) begin
      rsp_onehot[r] = (tag_id[L-1] == IDW'(r));
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= '0;
      rsp_id_o    <= '0;
      rsp_res_o   <= '0;
    end else if (tag_v[L-1]) begin
      rsp_valid_o <= rsp_onehot;
      rsp_id_o    <= tag_id[L-1];
      rsp_res_o   <= alu_res_i;
    end else begin
      rsp_valid_o <= '0;
    end
  end

  assign busy_o = (|tag_v) | (|rsp_valid_o);

endmodule

`default_nettype wire

// File: doc/alu_simd_arbiter.md
Name: alu_simd_arbiter

Overview:
- Shares one pipelined N-lane SIMD adder between M requesters.
- Each cycle, a round-robin arbiter grants at most one requester. The granted operand vectors drive the adder inputs.
- A tag pipeline matched to the adder latency returns each result to its requester, with the requester ID.
- Sits between client blocks and the SIMD adder instance; the adder receives the same clk_i/rst_i.

Parameters:
- M, 4, number of requesters (M >= 1)
- N, 4, number of adder lanes
- W, 20, lane width in bits
- L, 2, adder latency in cycles, from operands presented to result valid on alu_res_i (L >= 1)
- IDW, $clog2(M) (min 1), requester ID width (derived, not overridable)

Ports:
- clk_i  input  1  clock, all logic on rising edge
- rst_i  input  1  reset, asynchronous, active-high
- req_valid_i  input  M  per-requester operand-valid
- req_ready_o  output  M  per-requester grant, one-hot or zero
- req_a_i  input  M*N*W  operand A vectors; requester r at bits [r*N*W +: N*W], lane k at [k*W +: W] within that
- req_b_i  input  M*N*W  operand B vectors, same packing
- alu_a_o  output  N*W  operand A to adder
- alu_b_o  output  N*W  operand B to adder
- alu_res_i  input  N*W  result from adder
- rsp_valid_o  output  M  one-hot response strobe, one cycle
- rsp_id_o  output  IDW  ID of the responding requester
- rsp_res_o  output  N*W  result vector
- busy_o  output  1  high while any operation is in flight

Behaviour:
- Handshake: a transfer occurs in a cycle where req_valid_i[r] && req_ready_o[r]. req_ready_o is combinational from req_valid_i and the pointer. It is never asserted for a non-valid requester.
- A requester holds valid and operands stable until granted. Dropping valid before grant is allowed; nothing is issued.
- Round-robin arbitration:
  - Pointer ptr (IDW bits), reset 0.
  - The grant goes to the first valid requester scanning ptr, ptr+1, …, M-1, 0, …, ptr-1.
  - On a grant to g, ptr <= (g+1) mod M. With no grant, ptr holds.
- Operand mux: alu_a_o/alu_b_o = operands of the granted requester. With no grant, both drive all-zero (combinational).
- Throughput: one issue per cycle. No backpressure from the adder or the response side.
- Tag pipeline: L stages of {valid, id}, shifted every cycle, stage 0 loaded with {grant, g}.
- Response register:
  - On the cycle stage L-1 is valid, the next edge registers rsp_res_o <= alu_res_i, rsp_id_o <= id, rsp_valid_o <= one-hot(id). Otherwise rsp_valid_o <= 0.
  - rsp_res_o and rsp_id_o hold their last value when there is no response.
- Latency: handshake at edge E → rsp_valid_o high for exactly the one cycle following edge E+L (L+1 cycles later). Responses return in issue order.
- Width: lanes are independent mod 2^W. Carries never cross lanes (the adder's property); this block passes data unmodified.
- busy_o = OR of tag stage valids OR rsp_valid_o.
- Reset (asynchronous, mid-operation included):
  - ptr=0, all tag stages invalid, rsp_valid_o=0, rsp_id_o=0, rsp_res_o=0, busy_o=0.
  - In-flight operations are dropped with no response.
  - req_ready_o=0 while rst_i is high.
- Boundaries:
  - M=1: requester 0 is granted whenever valid; rsp_id_o is constant 0.
  - Requester valid every cycle, others idle: granted every cycle, back-to-back responses.
  - All requesters valid: grants rotate 0,1,…,M-1,0.
  - Idle cycles between grants do not reset ptr.

Test Plan:
- Reset, then a single request: r2 valid with a lane0=5, b lane0=7 (other lanes 0) → req_ready_o=4'b0100 that cycle. Three cycles later (L=2), rsp_valid_o=4'b0100, rsp_id_o=2, rsp_res_o lane0=12.
- All four valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3. Responses arrive in the same order with matching IDs, one per cycle.
- Lane wrap: a lane3=20'hFFFFF, b lane3=1, lane2 a=3, b=4 → lane3=0 and lane2=7; no carry into other lanes.
- Fairness after idle: grant to r1, two idle cycles, then r0 and r3 valid together → r3 granted first (ptr=2), then r0.
- Reset mid-flight: assert rst_i one cycle after two grants → no rsp_valid_o pulses afterward, busy_o=0 immediately, ptr=0.
- Valid withdrawn: r1 asserts valid, r0 is granted; r1 drops valid → r1 receives no response and no spurious rsp_valid_o occurs.
